// File: rtl/score_combo_engine.sv
// score_combo_engine: multi-lane rhythm-game scorer.
// Two-stage pipeline:
//   S1 condenses one judgement group into hit/miss counts and base points.
//   S2 applies the combo multiplier, then updates the saturating score and the combo.
// Optional build macro SCORE_MISS_PENALTY_EN: every missed lane subtracts PTS_MISS
// after the award, with a floor at zero.
module score_combo_engine #(
  parameter int LANES       = 4,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8,
  parameter int TIER_SIZE   = 16,
  parameter int MAX_MULT    = 17,
  parameter int PTS_GOOD    = 32,
  parameter int PTS_PERFECT = 256,
  parameter int PTS_MISS    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic [LANES-1:0]     i_judge_valid,
  input  logic [2*LANES-1:0]   i_judge_code,
  output logic [SCORE_W-1:0]   o_score,
  output logic [COMBO_W-1:0]   o_combo,
  output logic [COMBO_W-1:0]   o_max_combo,
  output logic [4:0]           o_multiplier,
  output logic                 o_update,
  output logic                 o_score_sat
);

  localparam int BASE_W = $clog2(LANES*PTS_PERFECT+1);
  localparam int CNT_W  = $clog2(LANES+1);
  localparam int WIDE_W = SCORE_W + 6;
  localparam logic [WIDE_W-1:0]  SCORE_MAX = {6'b0, {SCORE_W{1'b1}}};
  localparam logic [COMBO_W:0]   COMBO_MAX = {1'b0, {COMBO_W{1'b1}}};

  // Tiered multiplier: 1 with no combo, then +1 every TIER_SIZE hits, capped at MAX_MULT.
  function automatic logic [4:0] f_mult(input logic [COMBO_W-1:0] c);
    logic [31:0] t;
    if (c == '0) return 5'd1;
    t = 32'd2 + (32'(c) - 32'd1) / 32'(TIER_SIZE);
    if (t > 32'(MAX_MULT)) t = 32'(MAX_MULT);
    return t[4:0];
  endfunction

  logic              r_s1_vld;
  logic [CNT_W-1:0]  r_s1_hits, r_s1_miss;
  logic [BASE_W-1:0] r_s1_base;
  logic [SCORE_W-1:0] r_score;
  logic [COMBO_W-1:0] r_combo, r_max_combo;
  logic              r_update, r_score_sat;

  logic [CNT_W-1:0]   w_hits, w_miss;
  logic [BASE_W-1:0]  w_base;
  logic [4:0]         w_mult;
  logic [WIDE_W-1:0]  w_award, w_sum;
  logic               w_clamp;
  logic [SCORE_W-1:0] w_clamped, w_score_nxt;
  logic [COMBO_W:0]   w_combo_sum;
  logic [COMBO_W-1:0] w_combo_nxt;

  // Condense the lane judgements into hit/miss counts and base points.
  always_comb begin
    w_hits = '0;
    w_miss = '0;
    w_base = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i_judge_valid[i]) begin
        case (i_judge_code[2*i +: 2])
          2'b00: w_miss = w_miss + CNT_W'(1);
          2'b11: begin
            w_hits = w_hits + CNT_W'(1);
            w_base = w_base + BASE_W'(PTS_PERFECT);
          end
          default: begin
            w_hits = w_hits + CNT_W'(1);
            w_base = w_base + BASE_W'(PTS_GOOD);
          end
        endcase
      end
    end
  end

  // S1 register. A clear discards the group presented in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_hits <= '0;
      r_s1_miss <= '0;
      r_s1_base <= '0;
    end else begin
      r_s1_vld  <= !i_clear && (|i_judge_valid);
      r_s1_hits <= w_hits;
      r_s1_miss <= w_miss;
      r_s1_base <= w_base;
    end
  end

  // The award uses the combo from before this group, so the hits in a mixed hit/miss group
  // are paid at the old multiplier before the combo breaks.
  always_comb begin
    w_mult      = f_mult(r_combo);
    w_award     = WIDE_W'(r_s1_base) * WIDE_W'(w_mult);
    w_sum       = {6'b0, r_score} + w_award;
    w_clamp     = w_sum > SCORE_MAX;
    w_clamped   = w_clamp ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
    w_combo_sum = {1'b0, r_combo} + (COMBO_W+1)'(r_s1_hits);
    if (r_s1_miss != '0)
      w_combo_nxt = '0;
    else if (w_combo_sum > COMBO_MAX)
      w_combo_nxt = '1;
    else
      w_combo_nxt = w_combo_sum[COMBO_W-1:0];
  end

`ifdef SCORE_MISS_PENALTY_EN
  logic [WIDE_W-1:0] w_pen;
  // The penalty applies after the clamp; score_sat stays sticky.
  always_comb begin
    w_pen       = WIDE_W'(r_s1_miss) * WIDE_W'(PTS_MISS);
    w_score_nxt = (WIDE_W'(w_clamped) > w_pen) ? SCORE_W'(WIDE_W'(w_clamped) - w_pen) : '0;
  end
`else
  logic w_unused_pen;
  assign w_unused_pen = (PTS_MISS != 0);
  assign w_score_nxt  = w_clamped;
`endif

  // S2 register: score, combo, best combo, sticky saturation and the update pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_update    <= 1'b0;
      r_score_sat <= 1'b0;
    end else if (i_clear) begin
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_update    <= 1'b0;
      r_score_sat <= 1'b0;
    end else begin
      r_update <= r_s1_vld;
      if (r_s1_vld) begin
        r_score <= w_score_nxt;
        r_combo <= w_combo_nxt;
        if (w_combo_nxt > r_max_combo) r_max_combo <= w_combo_nxt;
        if (w_clamp) r_score_sat <= 1'b1;
      end
    end
  end

  assign o_score      = r_score;
  assign o_combo      = r_combo;
  assign o_max_combo  = r_max_combo;
  assign o_multiplier = w_mult;
  assign o_update     = r_update;
  assign o_score_sat  = r_score_sat;

endmodule
